dma_rdata_demux: RTL and testbench
==================================

Name: dma_rdata_demux

Overview:
- Return-path counterpart of the DMA channel source-select mux: routes AHB read data from the single DMA master port back to whichever of the two DMA channels issued the transfer.
- Tracks the AHB address/data pipeline, so each beat is tagged with its channel.
- Buffers each channel's beats in a small FIFO with valid/ready hand-off.
- Reports error responses per channel and gives per-channel issue credits to the address sequencer.

Parameters:
- DATA_W, 32, width of HRDATA and of the channel read-data outputs.
- DEPTH, 2, entries per channel FIFO; power of two, ≥2.

Ports:
- HCLK  input  1  system clock; all state updates on the rising edge.
- HRESETn  input  1  asynchronous, active-low reset.
- addr_valid  input  1  address phase of a NONSEQ/SEQ transfer is on the bus this cycle.
- addr_ch  input  1  channel owning that address phase (0 or 1).
- addr_write  input  1  1 = write transfer, 0 = read transfer.
- HREADY  input  1  AHB ready; the address phase and the data phase complete when this is high.
- HRESP  input  1  AHB response: 0 = OKAY, 1 = ERROR.
- HRDATA  input  DATA_W  AHB read data.
- ch0_rdata  output  DATA_W  head of the channel 0 FIFO.
- ch0_rvalid  output  1  channel 0 FIFO is non-empty.
- ch0_rready  input  1  channel 0 pops the head.
- ch1_rdata  output  DATA_W  head of the channel 1 FIFO.
- ch1_rvalid  output  1  channel 1 FIFO is non-empty.
- ch1_rready  input  1  channel 1 pops the head.
- ch_err  output  2  one-cycle pulse per channel when a transfer for that channel completes with ERROR.
- ch_credit  output  2  per channel: sequencer may issue a read for that channel this cycle.
- overflow  output  1  sticky flag: a read was issued without credit.

Behaviour:
- Reset (HRESETn low, asynchronous): both FIFOs empty, pointers 0, data-phase tracker cleared, ch0/ch1_rvalid=0, ch_err=0, overflow=0, ch_credit=2'b11, rdata outputs all zeros. Deassertion is handled by the system reset synchroniser.
- Reset mid-transfer: in-flight beat and FIFO contents are discarded.
- Data-phase tracker: registers dp_valid, dp_ch, dp_write.
  - On HREADY=1: dp_valid<=addr_valid, dp_ch<=addr_ch, dp_write<=addr_write.
  - On HREADY=0: tracker holds (wait states extend the data phase).
- Beat completion: dp_valid & HREADY.
  - Read with HRESP=0: push HRDATA into FIFO[dp_ch].
  - Any transfer with HRESP=1: ch_err[dp_ch] pulses high the next cycle; no push.
  - Write with OKAY: no effect.
  - The first ERROR cycle (HREADY=0) is ignored; only the completing cycle counts.
- Latency: a beat completing in cycle N appears on chX_rdata with chX_rvalid=1 in cycle N+1, if the FIFO was empty.
- FIFO:
  - Pop when chX_rvalid & chX_rready.
  - Push and pop in the same cycle: count unchanged, head advances, data order preserved.
  - rdata shows the head entry; its value is don't-care when empty.
  - Pointers wrap modulo DEPTH.
  - Count width is $clog2(DEPTH)+1.
- Credit:
  - pend[X] = dp_valid & ~dp_write & (dp_ch==X).
  - issued[X] = addr_valid & HREADY & ~addr_write & (addr_ch==X).
  - ch_credit[X] = (count[X] + pend[X]) < DEPTH. Combinational; a pop in the current cycle is not counted.
- Overflow:
  - Set if issued[X] occurs while ch_credit[X]=0.
  - Also set if a push targets a full FIFO with no simultaneous pop; that beat is dropped.
  - Cleared only by reset.
- Writes never consume credit.
- Channels are independent: a full channel 0 never blocks pushes to channel 1.

Test Plan:
- Read ch0 addr 0x100, HRDATA=0xDEADBEEF, HREADY=1, ch0_rready=1 -> ch0_rvalid=1 one cycle after the data phase, ch0_rdata=0xDEADBEEF, ch1_rvalid stays 0.
- Back-to-back reads ch0, ch1, ch0 with data 0x11, 0x22, 0x33 and two wait states on the second beat -> ch0 receives 0x11 then 0x33, ch1 receives 0x22, with no duplicates during the wait states.
- ch1_rready=0, two reads to ch1 (DEPTH=2) -> ch_credit[1]=0 once count+pend=2, ch_credit[0] stays 1; raise ch1_rready -> credit returns after the first pop.
- Issue a third ch1 read while ch_credit[1]=0 -> overflow=1 and remains 1 until HRESETn is asserted.
- Write ch0 with a two-cycle ERROR response (HREADY 0 then 1) -> ch_err=2'b01 for exactly one cycle; no FIFO push.
- Assert HRESETn=0 mid data phase with ch0 holding one entry -> ch0_rvalid=0 immediately (asynchronous), ch_credit=2'b11, overflow=0.

Source files
------------

// File: rtl/dma_rdata_demux.sv
// dma_rdata_demux: return-path demux for the two-channel DMA AHB master.
// Tracks the AHB address/data pipeline so each read beat is tagged with its
// owning channel, then buffers the beat in that channel's FIFO.
//
// Ports:
//   HCLK, HRESETn              clock, asynchronous active-low reset
//   addr_valid/addr_ch/addr_write   address phase on the bus this cycle
//   HREADY, HRESP, HRDATA      AHB data-phase handshake, response and read data
//   chX_rdata/chX_rvalid/chX_rready valid/ready read-data hand-off per channel
//   ch_err                     one-cycle per-channel ERROR pulse (registered)
//   ch_credit                  per-channel read issue credit (combinational)
//   overflow                   sticky: read issued without credit, or beat dropped
module dma_rdata_demux #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              addr_valid,
    input  logic              addr_ch,
    input  logic              addr_write,
    input  logic              HREADY,
    input  logic              HRESP,
    input  logic [DATA_W-1:0] HRDATA,
    output logic [DATA_W-1:0] ch0_rdata,
    output logic              ch0_rvalid,
    input  logic              ch0_rready,
    output logic [DATA_W-1:0] ch1_rdata,
    output logic              ch1_rvalid,
    input  logic              ch1_rready,
    output logic [1:0]        ch_err,
    output logic [1:0]        ch_credit,
    output logic              overflow
);

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    // Data-phase tracker
    logic dp_valid;
    logic dp_ch;
    logic dp_write;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_ch    <= 1'b0;
            dp_write <= 1'b0;
        end else if (HREADY) begin
            dp_valid <= addr_valid;
            dp_ch    <= addr_ch;
            dp_write <= addr_write;
        end
    end

    // Beat decode: only the completing cycle of a data phase counts
    logic              beat_done;
    logic [NUM_CH-1:0] push_req;
    logic [NUM_CH-1:0] err_c;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] issued;
    logic [NUM_CH-1:0] rready_v;
    logic [NUM_CH-1:0] rvalid_v;
    logic [NUM_CH-1:0] drop_v;
    logic [NUM_CH-1:0] credit_v;
    logic [DATA_W-1:0] rdata_v [NUM_CH];

    assign beat_done = dp_valid & HREADY;
    assign rready_v  = {ch1_rready, ch0_rready};

    always_comb begin
        push_req = '0;
        err_c    = '0;
        pend     = '0;
        issued   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            push_req[c] = beat_done & ~dp_write & ~HRESP & (dp_ch == 1'(c));
            err_c[c]    = beat_done & HRESP & (dp_ch == 1'(c));
            pend[c]     = dp_valid & ~dp_write & (dp_ch == 1'(c));
            issued[c]   = addr_valid & HREADY & ~addr_write & (addr_ch == 1'(c));
        end
    end

    // Per-channel FIFO and credit
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DATA_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [CNT_W-1:0]  count;
        logic              full;
        logic              pop;
        logic              do_push;
        logic [CNT_W:0]    occ;

        assign full    = (count == CNT_W'(DEPTH));
        assign pop     = (count != '0) & rready_v[g];
        // A full FIFO still accepts a beat when the head leaves the same cycle
        assign do_push = push_req[g] & (~full | pop);
        assign occ     = (CNT_W + 1)'(count) + (CNT_W + 1)'(pend[g]);

        assign drop_v[g]   = push_req[g] & full & ~pop;
        assign credit_v[g] = occ < (CNT_W + 1)'(DEPTH);
        assign rvalid_v[g] = (count != '0);
        assign rdata_v[g]  = mem[rd_ptr];

        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= HRDATA;
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (do_push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !do_push) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

    // Error pulse and sticky overflow
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ch_err   <= '0;
            overflow <= 1'b0;
        end else begin
            ch_err <= err_c;
            if ((|(issued & ~credit_v)) || (|drop_v)) begin
                overflow <= 1'b1;
            end
        end
    end

    assign ch_credit  = credit_v;
    assign ch0_rvalid = rvalid_v[0];
    assign ch1_rvalid = rvalid_v[1];
    assign ch0_rdata  = rdata_v[0];
    assign ch1_rdata  = rdata_v[1];

endmodule

// File: tb/tb_dma_rdata_demux.sv
// tb_dma_rdata_demux: scoreboard bench for dma_rdata_demux. Directed AHB
// sequences push the hand-computed read data / error pulses they expect; a
// negedge monitor pops and compares whenever the DUT hands a beat over or
// raises ch_err.
module tb_dma_rdata_demux;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 2;

    logic              HCLK = 1'b0;
    logic              HRESETn;
    logic              addr_valid, addr_ch, addr_write;
    logic              HREADY, HRESP;
    logic [DATA_W-1:0] HRDATA;
    logic [DATA_W-1:0] ch0_rdata, ch1_rdata;
    logic              ch0_rvalid, ch1_rvalid;
    logic              ch0_rready, ch1_rready;
    logic [1:0]        ch_err, ch_credit;
    logic              overflow;

    int n_pass  = 0;
    int n_total = 0;

    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    logic [1:0]        qe[$];

    dma_rdata_demux #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .addr_valid(addr_valid), .addr_ch(addr_ch), .addr_write(addr_write),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
        .ch0_rdata(ch0_rdata), .ch0_rvalid(ch0_rvalid), .ch0_rready(ch0_rready),
        .ch1_rdata(ch1_rdata), .ch1_rvalid(ch1_rvalid), .ch1_rready(ch1_rready),
        .ch_err(ch_err), .ch_credit(ch_credit), .overflow(overflow)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One bus cycle: inputs applied just after a rising edge, held to the next
    task automatic cyc(input logic av, input logic ach, input logic aw,
                       input logic rdy, input logic resp, input logic [DATA_W-1:0] d);
        addr_valid = av; addr_ch = ach; addr_write = aw;
        HREADY = rdy; HRESP = resp; HRDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    endtask

    // Monitor: compare every hand-off and error pulse against the scoreboard
    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (ch0_rvalid && ch0_rready) begin
                if (q0.size() == 0) chk("ch0_unexpected_beat", 64'(ch0_rdata), 64'hxBAD);
                else chk("ch0_rdata", 64'(ch0_rdata), 64'(q0.pop_front()));
            end
            if (ch1_rvalid && ch1_rready) begin
                if (q1.size() == 0) chk("ch1_unexpected_beat", 64'(ch1_rdata), 64'hxBAD);
                else chk("ch1_rdata", 64'(ch1_rdata), 64'(q1.pop_front()));
            end
            if (ch_err != 2'b00) begin
                if (qe.size() == 0) chk("unexpected_ch_err", 64'(ch_err), 64'h0);
                else chk("ch_err", 64'(ch_err), 64'(qe.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        HRESETn = 1'b0;
        addr_valid = 1'b0; addr_ch = 1'b0; addr_write = 1'b0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        ch0_rready = 1'b1; ch1_rready = 1'b1;
        repeat (2) @(posedge HCLK);
        #1;
        // Reset state
        chk("rst_ch0_rvalid", 64'(ch0_rvalid), 64'h0);
        chk("rst_ch1_rvalid", 64'(ch1_rvalid), 64'h0);
        chk("rst_ch_err",     64'(ch_err),     64'h0);
        chk("rst_ch_credit",  64'(ch_credit),  64'h3);
        chk("rst_overflow",   64'(overflow),   64'h0);
        chk("rst_ch0_rdata",  64'(ch0_rdata),  64'h0);
        HRESETn = 1'b1;
        idle(1);

        // Single read to ch0: visible the cycle after its data phase
        q0.push_back(32'hDEADBEEF);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
        chk("t1_ch0_rvalid", 64'(ch0_rvalid), 64'h1);
        chk("t1_ch0_rdata",  64'(ch0_rdata),  64'hDEADBEEF);
        chk("t1_ch1_rvalid", 64'(ch1_rvalid), 64'h0);
        idle(1);
        chk("t1_ch0_drained", 64'(ch0_rvalid), 64'h0);

        // ch0, ch1, ch0 back-to-back; two wait states on the ch1 beat
        q0.push_back(32'h11); q1.push_back(32'h22); q0.push_back(32'h33);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h11);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h99);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h98);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h22);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h33);
        idle(3);
        chk("t2_q0_empty", 64'(q0.size()), 64'h0);
        chk("t2_q1_empty", 64'(q1.size()), 64'h0);

        // ch1 credit with a stalled consumer, then overflow on a credit-less issue
        ch1_rready = 1'b0;
        q1.push_back(32'hA1); q1.push_back(32'hB2);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        chk("t3_credit_pend1", 64'(ch_credit), 64'h3);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA1);
        chk("t3_credit_cnt1_pend1", 64'(ch_credit), 64'h1);
        chk("t3_no_overflow", 64'(overflow), 64'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hB2);
        chk("t3_credit_full", 64'(ch_credit), 64'h1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        chk("t4_overflow_set", 64'(overflow), 64'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hC3);
        chk("t4_credit_still0", 64'(ch_credit), 64'h1);
        chk("t4_ch1_head", 64'(ch1_rdata), 64'hA1);
        ch1_rready = 1'b1;
        idle(1);
        chk("t3_credit_back", 64'(ch_credit), 64'h3);
        idle(1);
        chk("t3_ch1_drained", 64'(ch1_rvalid), 64'h0);
        chk("t4_overflow_sticky", 64'(overflow), 64'h1);
        chk("t3_q1_empty", 64'(q1.size()), 64'h0);

        // Write to ch0 with a two-cycle ERROR response
        qe.push_back(2'b01);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        chk("t5_no_err_first_cycle", 64'(ch_err), 64'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
        chk("t5_err_pulse", 64'(ch_err), 64'h1);
        chk("t5_no_push", 64'(ch0_rvalid), 64'h0);
        idle(1);
        chk("t5_err_cleared", 64'(ch_err), 64'h0);
        chk("t5_qe_empty", 64'(qe.size()), 64'h0);

        // Asynchronous reset mid data phase with ch0 holding one entry
        ch0_rready = 1'b0;
        q0.push_back(32'h55);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h55);
        chk("t6_ch0_holding", 64'(ch0_rvalid), 64'h1);
        #2;
        HRESETn = 1'b0;
        q0.delete();
        #1;
        chk("t6_rst_rvalid", 64'(ch0_rvalid), 64'h0);
        chk("t6_rst_credit", 64'(ch_credit), 64'h3);
        chk("t6_rst_overflow", 64'(overflow), 64'h0);
        chk("t6_rst_rdata", 64'(ch0_rdata), 64'h0);
        addr_valid = 1'b0; HRDATA = 32'h77;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        ch0_rready = 1'b1;
        idle(2);
        chk("t6_no_stale_beat", 64'(ch0_rvalid), 64'h0);
        chk("t6_final_q0", 64'(q0.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
